// File: rtl/pmem_arbiter_pkg.sv
// Shared types and constants for the physical-memory arbiter between the
// I-cache and D-cache line ports.
package pmem_arbiter_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;

  localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((1 << OFFSET_W) - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_t;

  typedef struct packed {
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [LINE_W-1:0] wdata;
  } pmem_req_t;

  // Line addresses go downstream with the byte offset cleared.
  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
    return addr & ~OFFSET_MASK;
  endfunction

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the two cache-side line ports and the downstream memory port.
// Handshake: a requester holds read/write (and address/wdata) high until it
// sees a single-cycle resp; rdata is only meaningful in that resp cycle.
interface pmem_arbiter_if;

  logic                                i_pmem_read;
  logic [pmem_arbiter_pkg::ADDR_W-1:0] i_pmem_address;
  logic [pmem_arbiter_pkg::LINE_W-1:0] i_pmem_rdata;
  logic                                i_pmem_resp;

  logic                                d_pmem_read;
  logic                                d_pmem_write;
  logic [pmem_arbiter_pkg::ADDR_W-1:0] d_pmem_address;
  logic [pmem_arbiter_pkg::LINE_W-1:0] d_pmem_wdata;
  logic [pmem_arbiter_pkg::LINE_W-1:0] d_pmem_rdata;
  logic                                d_pmem_resp;

  logic                                mem_read;
  logic                                mem_write;
  logic [pmem_arbiter_pkg::ADDR_W-1:0] mem_address;
  logic [pmem_arbiter_pkg::LINE_W-1:0] mem_wdata;
  logic [pmem_arbiter_pkg::LINE_W-1:0] mem_rdata;
  logic                                mem_resp;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  mem_rdata, mem_resp,
    output i_pmem_rdata, i_pmem_resp,
    output d_pmem_rdata, d_pmem_resp,
    output mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output mem_rdata, mem_resp,
    input  i_pmem_rdata, i_pmem_resp,
    input  d_pmem_rdata, d_pmem_resp,
    input  mem_read, mem_write, mem_address, mem_wdata
  );

endinterface

// File: rtl/pmem_req_reg.sv
// Grant-time latch: captures the winning request so the downstream port stays
// stable for the whole transaction regardless of requester inputs.
module pmem_req_reg
  import pmem_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  pmem_req_t req_i,
  output pmem_req_t req_o
);

  pmem_req_t req_q, req_d;

  always_comb begin
    req_d = req_q;
    if (load_i) req_d = req_i;
  end

  always_ff @(posedge clk) begin
    if (rst) req_q <= '0;
    else     req_q <= req_d;
  end

  assign req_o = req_q;

endmodule

// File: rtl/pmem_arbiter.sv
// Arbiter sharing one line-wide memory port between the I-cache and D-cache:
// one transaction at a time, IDLE gap between transactions.
module pmem_arbiter
  import pmem_arbiter_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  pmem_arbiter_if.slave bus,
  output logic          busy,
  output logic          last_grant,
  output arb_state_t    state_dbg_o
);

  arb_state_t state_q, state_d;
  arb_owner_t last_q, last_d, grant;
  logic       i_req, d_req, load, serving;
  pmem_req_t  req_d, req_q;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  // Contention goes to D under fixed priority, otherwise to whoever did not win last.
  always_comb begin
    grant = OWNER_I;
    if (d_req && !i_req) begin
      grant = OWNER_D;
    end else if (d_req && i_req) begin
      if (FIXED_PRIO || last_q == OWNER_I) grant = OWNER_D;
    end
  end

  // A D request with both read and write high is a write-back.
  always_comb begin
    req_d = '0;
    if (grant == OWNER_D) begin
      req_d.write   = bus.d_pmem_write;
      req_d.read    = ~bus.d_pmem_write;
      req_d.address = line_align(bus.d_pmem_address);
      req_d.wdata   = bus.d_pmem_wdata;
    end else begin
      req_d.read    = 1'b1;
      req_d.address = line_align(bus.i_pmem_address);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          load    = 1'b1;
          last_d  = grant;
          state_d = (grant == OWNER_D) ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= OWNER_D;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  pmem_req_reg u_req_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (load),
    .req_i  (req_d),
    .req_o  (req_q)
  );

  // Strobes are gated by state so a reset mid-transaction drops them at once.
  assign serving         = (state_q != IDLE);
  assign bus.mem_read    = serving & req_q.read;
  assign bus.mem_write   = serving & req_q.write;
  assign bus.mem_address = req_q.address;
  assign bus.mem_wdata   = req_q.wdata;

  assign bus.i_pmem_resp  = (state_q == SERVE_I) & bus.mem_resp;
  assign bus.d_pmem_resp  = (state_q == SERVE_D) & bus.mem_resp;
  assign bus.i_pmem_rdata = bus.mem_rdata;
  assign bus.d_pmem_rdata = bus.mem_rdata;

  assign busy        = serving;
  assign last_grant  = last_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: a round-robin instance and a fixed-priority instance
// share stimulus; sel chooses which one is observed and answered by memory.
module tb_pmem_arbiter;
  import pmem_arbiter_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bit sel = 1'b0;

  logic         i_req = 1'b0, d_rd = 1'b0, d_wr = 1'b0, m_resp = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [255:0] d_wd = '0, m_rdata = '0;

  pmem_arbiter_if bus0();
  pmem_arbiter_if bus1();

  assign bus0.i_pmem_read = i_req;    assign bus1.i_pmem_read = i_req;
  assign bus0.i_pmem_address = i_addr; assign bus1.i_pmem_address = i_addr;
  assign bus0.d_pmem_read = d_rd;     assign bus1.d_pmem_read = d_rd;
  assign bus0.d_pmem_write = d_wr;    assign bus1.d_pmem_write = d_wr;
  assign bus0.d_pmem_address = d_addr; assign bus1.d_pmem_address = d_addr;
  assign bus0.d_pmem_wdata = d_wd;    assign bus1.d_pmem_wdata = d_wd;
  assign bus0.mem_rdata = m_rdata;    assign bus1.mem_rdata = m_rdata;
  assign bus0.mem_resp = m_resp & !sel;
  assign bus1.mem_resp = m_resp & sel;

  logic busy0, busy1, lg0, lg1;
  arb_state_t st0, st1;

  pmem_arbiter #(.FIXED_PRIO(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .last_grant(lg0), .state_dbg_o(st0)
  );
  pmem_arbiter #(.FIXED_PRIO(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .last_grant(lg1), .state_dbg_o(st1)
  );

  logic         o_read, o_write, o_busy, o_lg, o_iresp, o_dresp;
  logic [31:0]  o_addr;
  logic [255:0] o_wdata, o_irdata, o_drdata;
  arb_state_t   o_state;

  assign o_read   = sel ? bus1.mem_read     : bus0.mem_read;
  assign o_write  = sel ? bus1.mem_write    : bus0.mem_write;
  assign o_addr   = sel ? bus1.mem_address  : bus0.mem_address;
  assign o_wdata  = sel ? bus1.mem_wdata    : bus0.mem_wdata;
  assign o_iresp  = sel ? bus1.i_pmem_resp  : bus0.i_pmem_resp;
  assign o_dresp  = sel ? bus1.d_pmem_resp  : bus0.d_pmem_resp;
  assign o_irdata = sel ? bus1.i_pmem_rdata : bus0.i_pmem_rdata;
  assign o_drdata = sel ? bus1.d_pmem_rdata : bus0.d_pmem_rdata;
  assign o_busy   = sel ? busy1 : busy0;
  assign o_lg     = sel ? lg1   : lg0;
  assign o_state  = sel ? st1   : st0;

  // ---------------- scoreboard / reference model ----------------
  int compared = 0;
  int mism = 0;
  logic [0:0] exp_q[$];
  logic m_last = 1'b1;   // owner of the most recent grant: 0 = I, 1 = D

  function automatic logic [255:0] rand_line();
    logic [255:0] v;
    for (int j = 0; j < 8; j++) v[j*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; m_resp = 1'b0;
    tick();
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic raise_d();
    int op;
    op = int'($urandom_range(0, 2));
    d_addr = $urandom;
    d_wd   = rand_line();
    d_rd   = (op != 1);
    d_wr   = (op != 0);
  endtask

  // Called in an IDLE cycle with at least one request up; acts as memory and
  // as the caches' request drop after resp.
  task automatic serve_one(input int lat, input bit wiggle, input logic [255:0] rd,
                           output logic owner);
    int           n;
    logic         er, ew;
    logic [31:0]  ea;
    logic [255:0] ewd;
    arb_state_t   es;
    if (i_req && (d_rd || d_wr)) owner = sel ? 1'b1 : ~m_last;
    else                         owner = d_rd | d_wr;
    er  = owner ? ~d_wr : 1'b1;
    ew  = owner ? d_wr : 1'b0;
    ea  = (owner ? d_addr : i_addr) & 32'hFFFF_FFE0;
    ewd = d_wd;
    es  = owner ? SERVE_D : SERVE_I;
    n = 0;
    while (!(o_read || o_write) && n < 20) begin
      tick();
      n++;
    end
    compared++;
    if (n !== 1) begin
      mism++;
      $display("FAIL grant_latency got %0d cycles exp 1", n);
      if (!(o_read || o_write)) return;
    end
    m_last = owner;
    compared++;
    if ({o_read, o_write, o_busy, o_lg} !== {er, ew, 1'b1, owner}) begin
      mism++;
      $display("FAIL grant_ctrl got rd=%b wr=%b busy=%b lg=%b exp rd=%b wr=%b busy=1 lg=%b",
               o_read, o_write, o_busy, o_lg, er, ew, owner);
    end
    compared++;
    if (o_addr !== ea || o_state !== es) begin
      mism++;
      $display("FAIL grant_addr got addr=%h state=%0d exp addr=%h state=%0d", o_addr, o_state, ea, es);
    end
    if (ew) begin
      compared++;
      if (o_wdata !== ewd) begin
        mism++;
        $display("FAIL grant_wdata got %h exp %h", o_wdata, ewd);
      end
    end
    for (int k = 0; k < lat; k++) begin
      if (wiggle) begin
        i_addr = $urandom; d_addr = $urandom; d_wd = rand_line();
        if (owner) begin d_rd = 1'b0; d_wr = 1'b0; end
        else i_req = 1'b0;
      end
      tick();
      compared++;
      if ({o_read, o_write, o_addr, o_iresp, o_dresp} !== {er, ew, ea, 2'b00}) begin
        mism++;
        $display("FAIL hold got rd=%b wr=%b addr=%h resp=%b%b exp rd=%b wr=%b addr=%h resp=00",
                 o_read, o_write, o_addr, o_iresp, o_dresp, er, ew, ea);
      end
      if (ew) begin
        compared++;
        if (o_wdata !== ewd) begin
          mism++;
          $display("FAIL hold_wdata got %h exp %h", o_wdata, ewd);
        end
      end
    end
    m_rdata = rd;
    m_resp  = 1'b1;
    #1;
    compared++;
    if ({o_iresp, o_dresp} !== {~owner, owner}) begin
      mism++;
      $display("FAIL resp_route got i=%b d=%b exp i=%b d=%b", o_iresp, o_dresp, ~owner, owner);
    end
    compared++;
    if (o_irdata !== rd || o_drdata !== rd) begin
      mism++;
      $display("FAIL rdata got i=%h d=%h exp %h", o_irdata, o_drdata, rd);
    end
    tick();
    compared++;
    if ({o_busy, o_read, o_write, o_iresp, o_dresp} !== 5'b0 || o_state !== IDLE) begin
      mism++;
      $display("FAIL idle_gap got busy=%b rd=%b wr=%b resp=%b%b state=%0d exp all 0 IDLE",
               o_busy, o_read, o_write, o_iresp, o_dresp, o_state);
    end
    m_resp = 1'b0;
    if (owner) begin d_rd = 1'b0; d_wr = 1'b0; end
    else i_req = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    compared++;
    if ({o_read, o_write, o_busy, o_iresp, o_dresp, o_lg} !== 6'b000001 || o_state !== IDLE) begin
      mism++;
      $display("FAIL reset_ctrl got rd=%b wr=%b busy=%b resp=%b%b lg=%b state=%0d exp 0 0 0 00 1 IDLE",
               o_read, o_write, o_busy, o_iresp, o_dresp, o_lg, o_state);
    end
    compared++;
    if (o_addr !== 32'h0 || o_wdata !== 256'h0) begin
      mism++;
      $display("FAIL reset_data got addr=%h wdata=%h exp 0", o_addr, o_wdata);
    end
    rst = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic test_idle_resp();
    m_rdata = rand_line();
    m_resp  = 1'b1;
    #1;
    compared++;
    if ({o_iresp, o_dresp} !== 2'b00) begin
      mism++;
      $display("FAIL idle_resp got i=%b d=%b exp 0 0", o_iresp, o_dresp);
    end
    tick();
    compared++;
    if (o_state !== IDLE || o_busy !== 1'b0) begin
      mism++;
      $display("FAIL idle_resp_state got state=%0d busy=%b exp IDLE 0", o_state, o_busy);
    end
    m_resp = 1'b0;
  endtask

  task automatic test_i_read();
    logic own;
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    i_addr = 32'h0000_1234;
    i_req  = 1'b1;
    serve_one(4, 1'b0, a5, own);
    compared++;
    if (own !== 1'b0) begin
      mism++;
      $display("FAIL i_read_owner got %b exp 0", own);
    end
  endtask

  task automatic test_d_write();
    logic own;
    d_addr = 32'h8000_0040;
    d_wd   = {2{128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00}};
    d_wr   = 1'b1;
    serve_one(3, 1'b0, rand_line(), own);
    compared++;
    if (own !== 1'b1) begin
      mism++;
      $display("FAIL d_write_owner got %b exp 1", own);
    end
  endtask

  task automatic test_contention();
    logic own;
    logic [0:0] e;
    do_reset();
    i_req = 1'b1; i_addr = $urandom;
    d_rd  = 1'b1; d_addr = $urandom;
    exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    for (int k = 0; k < 2; k++) begin
      serve_one(int'($urandom_range(0, 4)), 1'b0, rand_line(), own);
      e = exp_q.pop_front();
      compared++;
      if (own !== e) begin
        mism++;
        $display("FAIL contention_order txn %0d got %b exp %b", k, own, e);
      end
    end
    compared++;
    if (o_lg !== 1'b1) begin
      mism++;
      $display("FAIL contention_last_grant got %b exp 1", o_lg);
    end
  endtask

  task automatic test_sustained(input bit fixed);
    logic own;
    logic [0:0] e;
    i_req = 1'b1; i_addr = $urandom;
    d_rd  = 1'b1; d_wr = 1'b0; d_addr = $urandom;
    for (int k = 0; k < 6; k++) exp_q.push_back(fixed ? 1'b1 : ((k % 2) == 1));
    for (int k = 0; k < 6; k++) begin
      serve_one(int'($urandom_range(0, 3)), 1'b0, rand_line(), own);
      e = exp_q.pop_front();
      compared++;
      if (own !== e) begin
        mism++;
        $display("FAIL sustained_order fixed=%b txn %0d got %b exp %b", fixed, k, own, e);
      end
      if (k < 5) begin
        if (own) begin d_rd = 1'b1; d_addr = $urandom; end
        else begin i_req = 1'b1; i_addr = $urandom; end
      end
    end
    if (fixed) begin
      serve_one(1, 1'b0, rand_line(), own);
      compared++;
      if (own !== 1'b0) begin
        mism++;
        $display("FAIL fixed_then_i got %b exp 0", own);
      end
    end
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic test_mid_change();
    logic [255:0] rd;
    i_addr = 32'h0; i_req = 1'b1;
    tick();
    m_last = 1'b0;
    compared++;
    if ({o_read, o_write, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
      mism++;
      $display("FAIL mid_grant got rd=%b wr=%b addr=%h exp 1 0 00000000", o_read, o_write, o_addr);
    end
    i_addr = 32'hFFFF_FFE0; i_req = 1'b0; d_addr = $urandom;
    for (int k = 0; k < 3; k++) begin
      tick();
      compared++;
      if ({o_read, o_write, o_addr} !== {1'b1, 1'b0, 32'h0}) begin
        mism++;
        $display("FAIL mid_hold cycle %0d got rd=%b wr=%b addr=%h exp 1 0 00000000", k, o_read, o_write, o_addr);
      end
    end
    rd = rand_line();
    m_rdata = rd; m_resp = 1'b1;
    #1;
    compared++;
    if ({o_iresp, o_dresp} !== 2'b10 || o_irdata !== rd) begin
      mism++;
      $display("FAIL mid_resp got i=%b d=%b rdata=%h exp 1 0 %h", o_iresp, o_dresp, o_irdata, rd);
    end
    tick();
    m_resp = 1'b0;
    compared++;
    if (o_busy !== 1'b0) begin
      mism++;
      $display("FAIL mid_done got busy=%b exp 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic own;
    d_rd = 1'b1; d_addr = $urandom;
    repeat (2) tick();
    rst = 1'b1; d_rd = 1'b0;
    tick();
    compared++;
    if ({o_read, o_write, o_busy, o_lg} !== 4'b0001 || o_state !== IDLE) begin
      mism++;
      $display("FAIL reset_mid got rd=%b wr=%b busy=%b lg=%b state=%0d exp 0 0 0 1 IDLE",
               o_read, o_write, o_busy, o_lg, o_state);
    end
    rst = 1'b0;
    m_last = 1'b1;
    i_req = 1'b1; i_addr = $urandom;
    serve_one(2, 1'b0, rand_line(), own);
    compared++;
    if (own !== 1'b0) begin
      mism++;
      $display("FAIL reset_mid_recover got %b exp 0", own);
    end
  endtask

  task automatic test_random();
    logic own;
    for (int it = 0; it < 30; it++) begin
      if (!i_req && $urandom_range(0, 1) == 1) begin i_req = 1'b1; i_addr = $urandom; end
      if (!(d_rd || d_wr) && $urandom_range(0, 1) == 1) raise_d();
      if (!i_req && !(d_rd || d_wr)) begin i_req = 1'b1; i_addr = $urandom; end
      serve_one(int'($urandom_range(0, 5)), bit'($urandom_range(0, 1)), rand_line(), own);
    end
    i_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_idle_resp();
    test_i_read();
    test_d_write();
    test_contention();
    test_sustained(1'b0);
    test_mid_change();
    test_reset_mid();
    test_random();
    sel = 1'b1;
    do_reset();
    test_sustained(1'b1);
    test_random();
    sel = 1'b0;
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after 2000000 time units, exp completion");
    $fatal(1);
  end

endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Shares the single 256-bit physical-memory port between the pipelined I-cache (read-only) and the pipelined D-cache (read/write-back).
- Sits between both cache controllers and the cacheline adaptor / main memory.
- Grants one line transaction at a time. Latches the request at grant, holds it steady downstream until mem_resp, then routes the response back to the granted cache.

Parameters:
- LINE_W, 256, cacheline width in bits
- ADDR_W, 32, physical address width
- OFFSET_W, 5, line-offset bits forced to zero on mem_address (log2(LINE_W/8))
- FIXED_PRIO, 0, 0 = round-robin on contention; 1 = D-cache always wins contention

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- i_pmem_read  in  1  I-cache line-read request
- i_pmem_address  in  ADDR_W  I-cache line address
- i_pmem_rdata  out  LINE_W  line data to I-cache
- i_pmem_resp  out  1  I-cache transaction complete
- d_pmem_read  in  1  D-cache line-read request
- d_pmem_write  in  1  D-cache write-back request
- d_pmem_address  in  ADDR_W  D-cache line address
- d_pmem_wdata  in  LINE_W  D-cache write-back line
- d_pmem_rdata  out  LINE_W  line data to D-cache
- d_pmem_resp  out  1  D-cache transaction complete
- mem_read  out  1  downstream read strobe
- mem_write  out  1  downstream write strobe
- mem_address  out  ADDR_W  downstream line address
- mem_wdata  out  LINE_W  downstream write line
- mem_rdata  in  LINE_W  downstream read line
- mem_resp  in  1  downstream completion
- busy  out  1  arbiter not in IDLE
- last_grant  out  1  0 = I-cache, 1 = D-cache; owner of the most recent grant

Behaviour:
- Reset (sync, rst=1 at a posedge):
  - state=IDLE, last_grant=1 (so the I-cache wins the first contention).
  - mem_read=mem_write=0, mem_address=0, mem_wdata=0.
  - i_pmem_resp=d_pmem_resp=0, busy=0.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Requests are sampled only in this state.
  - Only I requests -> SERVE_I. Only D requests (read or write) -> SERVE_D.
  - Both request, FIXED_PRIO=0 -> grant the requester that is not last_grant. FIXED_PRIO=1 -> grant D.
  - No request -> stay in IDLE.
  - On the grant edge:
    - Register address with the low OFFSET_W bits cleared.
    - Register the op (read or write) and, for D, wdata.
    - Update last_grant.
- SERVE_x:
  - mem_read/mem_write driven from the registered op; mem_address/mem_wdata from registers. All are stable for the whole transaction, independent of requester inputs.
  - Stay until mem_resp=1.
  - In the mem_resp cycle, the granted x_pmem_resp=1 combinationally (same cycle); the other resp stays 0. Next state is IDLE.
- Latency:
  - Request visible in IDLE at cycle N -> mem strobe asserted at N+1 -> resp to the cache in the same cycle as mem_resp.
  - One mandatory IDLE cycle separates back-to-back transactions.
- Data return: mem_rdata is broadcast combinationally to both i_pmem_rdata and d_pmem_rdata. Only resp qualifies it.
- Requester contract: a cache deasserts its request in the cycle after its resp. A request still high in the following IDLE cycle is treated as a new transaction.
- d_pmem_read and d_pmem_write both high: treated as a write.
- mem_resp in IDLE: ignored; no resp forwarded.
- Request dropped mid-SERVE: the transaction still completes downstream. resp is still pulsed.
- Reset mid-SERVE: abandon the transaction. Strobes drop on the next edge and the state goes to IDLE.
- mem_read and mem_write are never simultaneously 1.

Decomposition:
- The shared package holds:
  - the enum arb_state_t {IDLE, SERVE_I, SERVE_D};
  - the enum arb_owner_t {OWNER_I=0, OWNER_D=1};
  - the struct pmem_req_t {read, write, address, wdata}.
- One natural sub-module: pmem_req_reg, the grant-time request latch. It takes a load enable and a pmem_req_t and returns the held pmem_req_t.
- State logic stays in the top.

Test Plan:
- I-only read, addr 0x0000_1234:
  - mem_read=1 with mem_address=0x0000_1220 one cycle after the request.
  - Memory returns line 0xA5..A5 after 4 cycles -> i_pmem_resp=1 in that cycle with i_pmem_rdata=0xA5..A5; d_pmem_resp=0.
- D write-back, addr 0x8000_0040, wdata 0x1122..FF:
  - mem_write=1, mem_wdata matches, mem_read=0 throughout.
  - d_pmem_resp pulses once.
- Simultaneous I and D reads after reset, FIXED_PRIO=0:
  - I is served first.
  - After one IDLE gap, D is served.
  - last_grant=1 at the end.
- Sustained contention for 6 transactions:
  - Grants alternate I, D, I, D, I, D.
  - Rerun with FIXED_PRIO=1 -> all D while D keeps requesting.
- Request inputs changed mid-SERVE (address 0x0 -> 0xFFFF_FFE0):
  - mem_address holds the latched value until mem_resp.
- rst asserted two cycles into SERVE_D:
  - Next edge: mem_read=mem_write=0, busy=0, state IDLE.
  - A later I request is then served normally.
